// File: rtl/vm2_board_ctrl_if.sv
// CPU-side vector/ack and Wishbone handshake signals of the VM2 board-control block.
interface vm2_board_ctrl_if;
  logic        una_i;
  logic [15:0] ivec_i;
  logic        istb_i;
  logic        iack_i;
  logic [15:0] vec_o;
  logic        istb_o;
  logic        iack_o;
  logic        wb_stb_i;
  logic        wb_ack_i;
  logic        ack_o;
  logic        berr_o;

  modport slave (
    input  una_i, ivec_i, istb_i, iack_i, wb_stb_i, wb_ack_i,
    output vec_o, istb_o, iack_o, ack_o, berr_o
  );

  modport master (
    output una_i, ivec_i, istb_i, iack_i, wb_stb_i, wb_ack_i,
    input  vec_o, istb_o, iack_o, ack_o, berr_o
  );
endinterface

// File: rtl/vm2_board_ctrl.sv
// VM2 board control: slow-mode clock enable, EVNT tick with debounced button,
// UNA startup vector, optional bus-timeout watchdog (VM2_BUS_TIMEOUT_EN).
module vm2_board_ctrl #(
  parameter int unsigned SLOW_DIV   = 22,
  parameter int unsigned CLK_HZ     = 100000000,
  parameter int unsigned EVNT_HZ    = 50,
  parameter int unsigned DEB_LEN    = 2,
  parameter logic        TIMER_INIT = 1'b0,
  parameter logic [15:0] START_BASE = 16'o140000,
  parameter logic [2:0]  STARTUP    = 3'b001,
  parameter int unsigned TMO_CYCLES = 64
) (
  input  logic clk_p,
  input  logic reset,
  input  logic slow_i,
  output logic clk_ena_o,
  input  logic timer_button,
  output logic timer_status,
  output logic evnt_o,
  vm2_board_ctrl_if.slave bus
);

  localparam int unsigned TDIV = CLK_HZ / EVNT_HZ;
  localparam int unsigned DW   = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
  localparam int unsigned TW   = (TDIV > 1) ? $clog2(TDIV) : 1;

  logic [DW-1:0]      dcnt;
  logic [TW-1:0]      tcnt;
  logic               tick;
  logic               btn_s1;
  logic               btn_s2;
  logic               armed;
  logic [DEB_LEN-1:0] deb;
  logic [DEB_LEN-1:0] deb_next;

  // Holding dcnt at 0 in fast mode makes a later slow_i rise restart the count.
  always_ff @(posedge clk_p) begin
    if (reset) begin
      dcnt      <= '0;
      clk_ena_o <= 1'b0;
    end else if (!slow_i) begin
      dcnt      <= '0;
      clk_ena_o <= 1'b1;
    end else begin
      clk_ena_o <= (dcnt == DW'(SLOW_DIV - 1));
      dcnt      <= (dcnt == DW'(SLOW_DIV - 1)) ? '0 : dcnt + DW'(1);
    end
  end

  assign tick = (tcnt == TW'(TDIV - 1));

  always_comb begin
    deb_next    = deb;
    deb_next[0] = btn_s2;
    for (int unsigned i = 1; i < DEB_LEN; i++) deb_next[i] = deb[i-1];
  end

  // Pattern decisions use deb_next so a toggle lands on the completing tick.
  always_ff @(posedge clk_p) begin
    if (reset) begin
      tcnt         <= '0;
      evnt_o       <= 1'b0;
      btn_s1       <= 1'b0;
      btn_s2       <= 1'b0;
      deb          <= '0;
      armed        <= 1'b1;
      timer_status <= TIMER_INIT;
    end else begin
      btn_s1 <= timer_button;
      btn_s2 <= btn_s1;
      tcnt   <= tick ? '0 : tcnt + TW'(1);
      evnt_o <= tick & timer_status;
      if (tick) begin
        deb <= deb_next;
        if ((&deb_next) && armed) begin
          timer_status <= ~timer_status;
          armed        <= 1'b0;
        end else if (~|deb_next) begin
          armed <= 1'b1;
        end
      end
    end
  end

  assign bus.vec_o  = bus.una_i ? {START_BASE[15:3], STARTUP} : bus.ivec_i;
  assign bus.istb_o = bus.istb_i & ~bus.una_i;
  assign bus.iack_o = bus.iack_i | bus.una_i;

`ifdef VM2_BUS_TIMEOUT_EN
  localparam int unsigned WW = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;

  logic [WW-1:0] wcnt;
  logic          blocked;
  logic          tmo;

  assign tmo = bus.wb_stb_i & ~bus.wb_ack_i & ~blocked & (wcnt == WW'(TMO_CYCLES - 1));

  always_ff @(posedge clk_p) begin
    if (reset || !bus.wb_stb_i) begin
      wcnt    <= '0;
      blocked <= 1'b0;
    end else if (bus.wb_ack_i) begin
      wcnt <= '0;
    end else if (!blocked) begin
      if (tmo) begin
        wcnt    <= '0;
        blocked <= 1'b1;
      end else begin
        wcnt <= wcnt + WW'(1);
      end
    end
  end

  assign bus.ack_o  = bus.wb_ack_i | tmo;
  assign bus.berr_o = tmo;
`else
  logic unused_stb;
  assign unused_stb = bus.wb_stb_i;
  assign bus.ack_o  = bus.wb_ack_i;
  assign bus.berr_o = 1'b0;
`endif

endmodule
